// File: rtl/gbuff_banked_if.sv
// Request/response bundle for one gbuff_banked access port.
// The master drives the request and the slave returns the grant and read data.
interface gbuff_banked_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8
);
  logic                  req;
  logic                  we;
  logic [ADDR_W-1:0]     addr;
  logic [DATA_W-1:0]     wdata;
  logic [DATA_W/8-1:0]   wmask;
  logic                  gnt;
  logic                  rvalid;
  logic [DATA_W-1:0]     rdata;

  modport master (output req, we, addr, wdata, wmask, input gnt, rvalid, rdata);
  modport slave  (input req, we, addr, wdata, wmask, output gnt, rvalid, rdata);
endinterface

// File: rtl/gbuff_banked.sv
// Dual-port, low-order interleaved banked global buffer with round-robin same-bank arbitration.
// Define GBUFF_CLEAR_EN to zero the whole array in a ROWS-cycle sweep after every reset.
module gbuff_banked #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8,
  parameter int BANK_W = 2
) (
  input  logic                clk,
  input  logic                rst,
  gbuff_banked_if.slave       a,
  gbuff_banked_if.slave       b,
  output logic                ready,
  output logic [15:0]         conflict_cnt
);
  localparam int BANKS  = 1 << BANK_W;
  localparam int ROW_W  = ADDR_W - BANK_W;
  localparam int ROWS   = 1 << ROW_W;
  localparam int MASK_W = DATA_W / 8;

  typedef logic [BANK_W-1:0] bank_t;
  typedef logic [ROW_W-1:0]  row_t;

  function automatic logic [DATA_W-1:0] merge_bytes(input logic [DATA_W-1:0] old_w,
                                                    input logic [DATA_W-1:0] new_w,
                                                    input logic [MASK_W-1:0] mask);
    logic [DATA_W-1:0] res;
    for (int i = 0; i < MASK_W; i++)
      res[8*i +: 8] = mask[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
    return res;
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [DATA_W-1:0] mem [BANKS][ROWS];

  bank_t a_bank, b_bank;
  row_t  a_row, b_row;
  logic  conflict;
  logic  clearing;
  row_t  clr_row;

  assign a_bank = a.addr[BANK_W-1:0];
  assign b_bank = b.addr[BANK_W-1:0];
  assign a_row  = a.addr[ADDR_W-1:BANK_W];
  assign b_row  = b.addr[ADDR_W-1:BANK_W];

`ifdef GBUFF_CLEAR_EN
  typedef enum logic {S_CLEAR, S_RUN} state_t;
  state_t state_q, state_d;
  row_t   clr_row_q, clr_row_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_CLEAR;
      clr_row_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_row_q <= clr_row_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_row_d = clr_row_q;
    case (state_q)
      S_CLEAR: begin
        clr_row_d = clr_row_q + row_t'(1);
        if (clr_row_q == row_t'(ROWS - 1)) state_d = S_RUN;
      end
      default: state_d = S_RUN;
    endcase
  end

  always_comb begin
    ready    = (state_q == S_RUN);
    clearing = (state_q == S_CLEAR);
    clr_row  = clr_row_q;
  end
`else
  assign ready    = 1'b1;
  assign clearing = 1'b0;
  assign clr_row  = '0;
`endif

  // Arbitration: the prio holder wins a same-bank collision, then prio passes to the loser.
  logic        prio_q, prio_d;
  logic [15:0] cnt_q, cnt_d;

  assign conflict = a.req & b.req & (a_bank == b_bank);
  assign a.gnt    = ready & a.req & (~conflict | ~prio_q);
  assign b.gnt    = ready & b.req & (~conflict |  prio_q);

  always_comb begin
    prio_d = prio_q;
    cnt_d  = cnt_q;
    if (ready & conflict) begin
      prio_d = ~prio_q;
      cnt_d  = sat_inc(cnt_q);
    end
  end

  logic [BANKS-1:0]  wr_en;
  row_t              wr_row  [BANKS];
  logic [DATA_W-1:0] wr_data [BANKS];
  logic [MASK_W-1:0] wr_mask [BANKS];

  always_comb begin
    for (int i = 0; i < BANKS; i++) begin
      wr_en[i]   = 1'b0;
      wr_row[i]  = '0;
      wr_data[i] = '0;
      wr_mask[i] = '0;
      if (clearing) begin
        wr_en[i]   = 1'b1;
        wr_row[i]  = clr_row;
        wr_mask[i] = '1;
      end else if (a.gnt & a.we & (a_bank == bank_t'(i))) begin
        wr_en[i]   = 1'b1;
        wr_row[i]  = a_row;
        wr_data[i] = a.wdata;
        wr_mask[i] = a.wmask;
      end else if (b.gnt & b.we & (b_bank == bank_t'(i))) begin
        wr_en[i]   = 1'b1;
        wr_row[i]  = b_row;
        wr_data[i] = b.wdata;
        wr_mask[i] = b.wmask;
      end
      // A reset edge discards any access presented alongside it.
      if (rst) wr_en[i] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < BANKS; i++)
      if (wr_en[i])
        mem[i][wr_row[i]] <= merge_bytes(mem[i][wr_row[i]], wr_data[i], wr_mask[i]);
  end

  logic              a_rvalid_q, a_rvalid_d, b_rvalid_q, b_rvalid_d;
  logic [DATA_W-1:0] a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;

  always_comb begin
    a_rvalid_d = a.gnt & ~a.we;
    b_rvalid_d = b.gnt & ~b.we;
    a_rdata_d  = a_rvalid_d ? mem[a_bank][a_row] : a_rdata_q;
    b_rdata_d  = b_rvalid_d ? mem[b_bank][b_row] : b_rdata_q;
  end

  // Read stage: one registered cycle from grant to rvalid/rdata.
  always_ff @(posedge clk) begin
    if (rst) begin
      prio_q     <= 1'b0;
      cnt_q      <= '0;
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
      a_rdata_q  <= '0;
      b_rdata_q  <= '0;
    end else begin
      prio_q     <= prio_d;
      cnt_q      <= cnt_d;
      a_rvalid_q <= a_rvalid_d;
      b_rvalid_q <= b_rvalid_d;
      a_rdata_q  <= a_rdata_d;
      b_rdata_q  <= b_rdata_d;
    end
  end

  assign a.rvalid     = a_rvalid_q;
  assign b.rvalid     = b_rvalid_q;
  assign a.rdata      = a_rdata_q;
  assign b.rdata      = b_rdata_q;
  assign conflict_cnt = cnt_q;
endmodule

// File: tb/tb_gbuff_banked.sv
// Scoreboard bench for gbuff_banked: directed stimulus pushes expected reads, a monitor pops them.
// Works with and without GBUFF_CLEAR_EN defined.
module tb_gbuff_banked;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 8;
  localparam int BANK_W = 2;
`ifdef GBUFF_CLEAR_EN
  localparam int READY_EDGES = 64;
  localparam logic READY_RST = 1'b0;
`else
  localparam int READY_EDGES = 0;
  localparam logic READY_RST = 1'b1;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        ready;
  logic [15:0] conflict_cnt;

  always #5 clk = ~clk;

  gbuff_banked_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) a_if ();
  gbuff_banked_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) b_if ();

  gbuff_banked #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BANK_W(BANK_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .a            (a_if),
    .b            (b_if),
    .ready        (ready),
    .conflict_cnt (conflict_cnt)
  );

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t        q [2][$];
  logic [31:0] last_rd [2];
  logic [31:0] model [256];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  logic        rst_at_edge;

  always @(posedge clk) begin
    cyc         <= cyc + 1;
    rst_at_edge <= rst;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                        input logic [3:0] m);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = m[i] ? n[8*i +: 8] : o[8*i +: 8];
    return r;
  endfunction

  task automatic mon(input int p, input logic rv, input logic [31:0] rd);
    exp_t e;
    if (rst_at_edge === 1'b1) begin
      last_rd[p] = '0;
      check($sformatf("rst_rvalid_%0d", p), {31'b0, rv}, 32'd0);
      check($sformatf("rst_rdata_%0d", p), rd, 32'd0);
    end else if (rv === 1'b1) begin
      if (q[p].size() == 0) begin
        check($sformatf("spurious_rvalid_%0d", p), {31'b0, rv}, 32'd0);
      end else begin
        e = q[p].pop_front();
        check($sformatf("rdata_%0d", p), rd, e.data);
        check($sformatf("rd_latency_%0d", p), cyc, e.cyc);
        last_rd[p] = e.data;
      end
    end else if (rst_at_edge === 1'b0) begin
      check($sformatf("rdata_hold_%0d", p), rd, last_rd[p]);
    end
  endtask

  always @(negedge clk) begin
    mon(0, a_if.rvalid, a_if.rdata);
    mon(1, b_if.rvalid, b_if.rdata);
  end

  task automatic drv(input int p, input logic rq, input logic w, input logic [7:0] ad,
                     input logic [31:0] wd, input logic [3:0] m);
    if (p == 0) begin
      a_if.req = rq; a_if.we = w; a_if.addr = ad; a_if.wdata = wd; a_if.wmask = m;
    end else begin
      b_if.req = rq; b_if.we = w; b_if.addr = ad; b_if.wdata = wd; b_if.wmask = m;
    end
  endtask

  // Called just after a negedge with inputs already driven; returns at the next negedge.
  task automatic step(input logic ega, input logic egb, input string tag);
    #1;
    check({tag, "_a_gnt"}, {31'b0, a_if.gnt}, {31'b0, ega});
    check({tag, "_b_gnt"}, {31'b0, b_if.gnt}, {31'b0, egb});
    if (ega && !a_if.we) q[0].push_back('{data: model[a_if.addr], cyc: cyc + 1});
    if (egb && !b_if.we) q[1].push_back('{data: model[b_if.addr], cyc: cyc + 1});
    @(posedge clk);
    if (ega && a_if.we) model[a_if.addr] = merge(model[a_if.addr], a_if.wdata, a_if.wmask);
    if (egb && b_if.we) model[b_if.addr] = merge(model[b_if.addr], b_if.wdata, b_if.wmask);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    drv(0, 0, 0, 8'h00, 32'h0, 4'h0);
    drv(1, 0, 0, 8'h00, 32'h0, 4'h0);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, "idle");
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (ready !== 1'b1 && n < 200) begin
      @(posedge clk);
      n++;
      #1;
    end
    check({tag, "_ready_edges"}, n, READY_EDGES);
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) model[i] = (READY_EDGES != 0) ? 32'h0 : 32'hx;
    last_rd[0] = '0;
    last_rd[1] = '0;
    rst = 1'b1;
    drv(0, 0, 0, 8'h00, 32'h0, 4'h0);
    drv(1, 0, 0, 8'h00, 32'h0, 4'h0);
    repeat (3) @(negedge clk);
    #1;
    check("rst_ready", {31'b0, ready}, {31'b0, READY_RST});
    check("rst_conflict_cnt", {16'b0, conflict_cnt}, 32'd0);
    check("rst_a_gnt", {31'b0, a_if.gnt}, 32'd0);
    rst = 1'b0;
    wait_ready("init");

`ifdef GBUFF_CLEAR_EN
    drv(0, 1, 0, 8'hA5, 32'h0, 4'h0);
    step(1'b1, 1'b0, "clr_rd");
    idle(1);
`endif

    // Parallel banks: writes to banks 0 and 1, then read back.
    drv(0, 1, 1, 8'd4, 32'hDEADBEEF, 4'hF);
    drv(1, 1, 1, 8'd5, 32'h12345678, 4'hF);
    step(1'b1, 1'b1, "par_wr");
    drv(0, 1, 0, 8'd4, 32'h0, 4'h0);
    drv(1, 1, 0, 8'd5, 32'h0, 4'h0);
    step(1'b1, 1'b1, "par_rd");
    idle(1);
    check("par_conflict_cnt", {16'b0, conflict_cnt}, 32'd0);

    // Seed bank-2 words for the collision test, banks 2 and 3 in parallel.
    drv(0, 1, 1, 8'd2, 32'hA0A00002, 4'hF);
    drv(1, 1, 1, 8'd7, 32'hB0B00007, 4'hF);
    step(1'b1, 1'b1, "seed1");
    drv(0, 1, 1, 8'd6, 32'h66666666, 4'hF);
    drv(1, 1, 1, 8'd3, 32'h33333333, 4'hF);
    step(1'b1, 1'b1, "seed2");

    // Byte mask, cross-port read-after-write, and an all-zero mask.
    drv(0, 1, 1, 8'd9, 32'hFFFFFFFF, 4'hF);
    drv(1, 0, 0, 8'd0, 32'h0, 4'h0);
    step(1'b1, 1'b0, "bm_full");
    drv(0, 0, 0, 8'd0, 32'h0, 4'h0);
    drv(1, 1, 1, 8'd9, 32'h00000000, 4'b0101);
    step(1'b0, 1'b1, "bm_part");
    drv(1, 0, 0, 8'd0, 32'h0, 4'h0);
    drv(0, 1, 0, 8'd9, 32'h0, 4'h0);
    step(1'b1, 1'b0, "bm_rd");
    check("bm_model", model[9], 32'hFF00FF00);
    drv(0, 0, 0, 8'd0, 32'h0, 4'h0);
    drv(1, 1, 1, 8'd9, 32'h12345678, 4'b0000);
    step(1'b0, 1'b1, "bm_zero");
    drv(1, 0, 0, 8'd0, 32'h0, 4'h0);
    drv(0, 1, 0, 8'd9, 32'h0, 4'h0);
    step(1'b1, 1'b0, "bm_rd2");
    idle(1);
    check("pre_rr_conflict_cnt", {16'b0, conflict_cnt}, 32'd0);

    // Sustained bank-2 collision: grants alternate A, B, A, B.
    drv(0, 1, 0, 8'd2, 32'h0, 4'h0);
    drv(1, 1, 0, 8'd6, 32'h0, 4'h0);
    step(1'b1, 1'b0, "rr1");
    step(1'b0, 1'b1, "rr2");
    step(1'b1, 1'b0, "rr3");
    step(1'b0, 1'b1, "rr4");
    idle(1);
    check("rr_conflict_cnt", {16'b0, conflict_cnt}, 32'd4);

    // Reset lands on the commit edge of a granted read.
    drv(0, 1, 0, 8'd4, 32'h0, 4'h0);
    #1;
    check("rst_rd_gnt", {31'b0, a_if.gnt}, 32'd1);
    #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    #1;
    check("midrst_ready", {31'b0, ready}, {31'b0, READY_RST});
    check("midrst_conflict_cnt", {16'b0, conflict_cnt}, 32'd0);
    rst = 1'b0;
    drv(0, 0, 0, 8'd0, 32'h0, 4'h0);
    if (READY_EDGES != 0)
      for (int i = 0; i < 256; i++) model[i] = 32'h0;
    wait_ready("midrst");

    drv(0, 1, 0, 8'd4, 32'h0, 4'h0);
    drv(1, 1, 0, 8'd5, 32'h0, 4'h0);
    step(1'b1, 1'b1, "post_rd");
    idle(2);

    check("qa_empty", q[0].size(), 32'd0);
    check("qb_empty", q[1].size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
